// File: rtl/sipo_pkg.sv
// Shared constants for the serial-in/parallel-out deserializer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sipo_pkg;

    // FSM encoding: assembling a word vs. presenting a finished word
    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] HOLD    = 1'b1;

    localparam int SIPO_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/sipo_bit_cell.sv
// One storage bit of the shift chain: load-enabled flop with async clear.
// Latency: 1 clock from d/en to q.
// Backpressure: none; en gates the load.
module sipo_bit_cell (
    input  logic clk,
    input  logic res,
    input  logic en,
    input  logic d,
    output logic q
);

    // Capture d when enabled; clear immediately on reset
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            q <= 1'b0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Assembles MSB-first serial bits into WIDTH-bit words; optional even parity (SIPO_PARITY_EN).
// Latency: dout_valid rises 1 clock after the last bit of a word is accepted.
// Backpressure: word held until dout_ready; bits arriving while held are dropped and flag overrun.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             res,
    input  logic             din,
    input  logic             din_valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    output logic             dout_par
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [0:0]       state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic             handshake;
    logic             take_bit;
    logic             word_done;
    logic             unused_shift_msb;

    // The handshake cycle also accepts a bit, so a continuous stream loses nothing
    assign handshake = (state == HOLD) && dout_ready;
    assign take_bit  = din_valid && ((state == COLLECT) || handshake);
    assign word_done = (state == COLLECT) && din_valid && (bit_cnt == LAST);
    assign shift_d   = {shift_q[WIDTH-2:0], din};

    // The oldest bit falls off the chain; the finished word is taken from shift_d
    assign unused_shift_msb = shift_q[WIDTH-1];

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_chain
            sipo_bit_cell u_cell (
                .clk (clk),
                .res (res),
                .en  (take_bit),
                .d   (shift_d[i]),
                .q   (shift_q[i])
            );
        end
    endgenerate

    // FSM and bit counter: wrap to 0 and enter HOLD on the last bit of a word
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state   <= COLLECT;
            bit_cnt <= '0;
        end else begin
            if (word_done) begin
                state <= HOLD;
            end else if (handshake) begin
                state <= COLLECT;
            end
            if (word_done) begin
                bit_cnt <= '0;
            end else if (take_bit) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // Output word is captured only on entry to HOLD and stays put otherwise
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            dout <= '0;
        end else if (word_done) begin
            dout <= shift_d;
        end
    end

    // Sticky overrun: a bit arrived while a word was waiting and not being consumed
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            overrun <= 1'b0;
        end else if ((state == HOLD) && !dout_ready && din_valid) begin
            overrun <= 1'b1;
        end
    end

    assign dout_valid = (state == HOLD);

`ifdef SIPO_PARITY_EN
    // Even parity registered alongside the word it describes
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            dout_par <= 1'b0;
        end else if (word_done) begin
            dout_par <= ^shift_d;
        end
    end
`else
    assign dout_par = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a word-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sipo_deserializer;

    localparam int W = 8;

    logic         clk;
    logic         res;
    logic         din;
    logic         din_valid;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         overrun;
    logic         dout_par;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: bits gathered so far, the last delivered word, hold/overrun flags
    int           m_bits[$];
    logic         m_hold;
    logic [W-1:0] m_word;
    logic         m_ovr;

    sipo_deserializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .res        (res),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overrun    (overrun),
        .dout_par   (dout_par)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_par(input logic [W-1:0] w);
`ifdef SIPO_PARITY_EN
        return ^w;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_reset();
        m_bits.delete();
        m_hold = 1'b0;
        m_word = '0;
        m_ovr  = 1'b0;
    endfunction

    // Word-level behaviour for one clock with the given inputs
    function automatic void model_step(input logic b, input logic v, input logic r);
        int acc;
        if (m_hold) begin
            if (r) begin
                m_hold = 1'b0;
                if (v) m_bits.push_back(int'(b));
            end else if (v) begin
                m_ovr = 1'b1;
            end
        end else if (v) begin
            m_bits.push_back(int'(b));
            if (m_bits.size() == W) begin
                acc = 0;
                foreach (m_bits[k]) acc = acc * 2 + m_bits[k];
                m_word = W'(acc);
                m_bits.delete();
                m_hold = 1'b1;
            end
        end
    endfunction

    task automatic compare_all();
        check("dout_valid", 32'(dout_valid), 32'(m_hold));
        check("dout",       32'(dout),       32'(m_word));
        check("overrun",    32'(overrun),    32'(m_ovr));
        check("dout_par",   32'(dout_par),   32'(exp_par(m_word)));
    endtask

    task automatic cycle(input logic b, input logic v, input logic r);
        din        = b;
        din_valid  = v;
        dout_ready = r;
        model_step(b, v, r);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic r);
        for (int i = W - 1; i >= 0; i--) cycle(w[i], 1'b1, r);
    endtask

    // Reset must clear outputs before any clock edge arrives
    task automatic do_reset();
        res        = 1'b0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        #2;
        check("rst_async_valid", 32'(dout_valid), 32'd0);
        check("rst_async_dout",  32'(dout),       32'd0);
        check("rst_async_ovr",   32'(overrun),    32'd0);
        check("rst_async_par",   32'(dout_par),   32'd0);
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        res = 1'b1;
    endtask

    initial begin
        logic [W-1:0] w;
        logic b, v, r;

        res        = 1'b0;
        din        = 1'b0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        model_reset();
        #3;
        do_reset();

        // Single word, no consumer
        send_word(8'hB2, 1'b0);
        check("word_b2_valid", 32'(dout_valid), 32'd1);
        check("word_b2_dout",  32'(dout),       32'hB2);
        check("word_b2_ovr",   32'(overrun),    32'd0);
        check("word_b2_par",   32'(dout_par),   32'(exp_par(8'hB2)));

        // Bit arriving during HOLD is dropped and flagged
        cycle(1'b1, 1'b1, 1'b0);
        check("ovr_set",      32'(overrun), 32'd1);
        check("ovr_dout_hold", 32'(dout),   32'hB2);
        cycle(1'b0, 1'b0, 1'b1);
        check("ovr_hs_valid", 32'(dout_valid), 32'd0);
        check("ovr_sticky",   32'(overrun),    32'd1);

        // Gapped arrival: 8 bits over 15 cycles
        do_reset();
        w = 8'hB2;
        for (int i = W - 1; i >= 0; i--) begin
            cycle(w[i], 1'b1, 1'b0);
            if (i != 0) cycle(1'($urandom), 1'b0, 1'b0);
        end
        check("gap_valid", 32'(dout_valid), 32'd1);
        check("gap_dout",  32'(dout),       32'hB2);
        cycle(1'b0, 1'b0, 1'b1);

        // Back-to-back words with a bit accepted in the handshake cycle
        do_reset();
        send_word(8'hB2, 1'b1);
        check("b2b_first",  32'(dout), 32'hB2);
        send_word(8'h5F, 1'b1);
        check("b2b_second", 32'(dout), 32'h5F);
        check("b2b_valid",  32'(dout_valid), 32'd1);
        check("b2b_ovr",    32'(overrun), 32'd0);
        cycle(1'b0, 1'b0, 1'b1);

        // Reset mid-word discards the partial word
        w = 8'hA5;
        for (int i = W - 1; i >= W - 5; i--) cycle(w[i], 1'b1, 1'b0);
        do_reset();
        send_word(8'hFF, 1'b0);
        check("rst_mid_dout", 32'(dout), 32'hFF);
        cycle(1'b0, 1'b0, 1'b1);
        send_word(8'h07, 1'b0);
        check("par_07_dout", 32'(dout), 32'h07);
`ifdef SIPO_PARITY_EN
        check("par_07", 32'(dout_par), 32'd1);
`else
        check("par_07", 32'(dout_par), 32'd0);
`endif
        cycle(1'b0, 1'b0, 1'b1);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                b = 1'($urandom);
                v = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 2) == 0);
                cycle(b, v, r);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
